// File: rtl/uart_frame_loader.sv
// uart_frame_loader: host frame intake (A5, LEN_H, LEN_L, payload, checksum)
// from a standard-mode RX FIFO into the image buffer, plus a single-writer
// TX scheduler that sends ACK/NAK and classifier result messages.
// Optional feature macro: UFL_TIMEOUT_EN (inter-byte timeout abort to HUNT with NAK).
//
// Handshakes: rd_uart is a one-cycle read strobe and the byte is taken from
// r_data in the following cycle; wr_uart is a write strobe only asserted when
// tx_full is low; res_valid is held by the classifier until res_ready pulses,
// which happens in the cycle the 0x5A header is written.
module uart_frame_loader #(
  parameter int ADDR_W         = 16,
  parameter int MAX_LEN        = 4096,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        r_data,
  input  logic              rx_empty,
  output logic              rd_uart,
  output logic [7:0]        w_data,
  output logic              wr_uart,
  input  logic              tx_full,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              frame_done,
  output logic [15:0]       frame_len,
  input  logic              res_valid,
  input  logic [7:0]        res_data,
  output logic              res_ready,
  output logic              busy,
  output logic [2:0]        rx_state_dbg,
  output logic [1:0]        tx_state_dbg
);

  typedef enum logic [2:0] {HUNT, LEN_H, LEN_L, PAYLOAD, CSUM} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_ACK, T_HDR, T_DATA} tx_state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [7:0]  ACK_BYTE  = 8'h06;
  localparam logic [7:0]  NAK_BYTE  = 8'h15;
  localparam logic [7:0]  RES_HDR   = 8'h5A;
  localparam logic [16:0] MAX_LEN_L = 17'(MAX_LEN);

  // Elaboration-time parameter sanity guards.
  if (MAX_LEN < 1 || MAX_LEN > (1 << ADDR_W) || MAX_LEN > 65535) begin : g_bad_max_len
    $error("uart_frame_loader: MAX_LEN out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 16777215) begin : g_bad_timeout
    $error("uart_frame_loader: TIMEOUT_CYCLES out of range");
  end

  rx_state_t   rx_state, rx_state_n;
  tx_state_t   tx_state, tx_state_n;
  logic        cap;          // r_data holds the byte fetched last cycle
  logic        rd_next;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  csum;
  logic        flag_pend;    // ACK/NAK waiting for the TX scheduler
  logic [7:0]  flag_byte;
  logic        flag_n;
  logic        flag_clr;
  logic        set_flag;
  logic [7:0]  set_byte;
  logic        good;
  logic        wr_pay;
  logic        tmo_hit;
  logic [7:0]  res_q;
  logic [15:0] new_len;

  assign new_len      = {len_hi, r_data};
  assign busy         = (rx_state != HUNT);
  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;

`ifdef UFL_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_L = 24'(TIMEOUT_CYCLES);
  logic [23:0] tmo_cnt;

  assign tmo_hit = (rx_state != HUNT) && (tmo_cnt == TIMEOUT_L);

  // Inter-byte idle counter: cleared by every captured byte and while hunting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else if (cap || rx_state == HUNT) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit) begin
      tmo_cnt <= tmo_cnt + 24'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // RX next state, frame events and the fetch decision for the next cycle.
  always_comb begin
    rx_state_n = rx_state;
    set_flag   = 1'b0;
    set_byte   = NAK_BYTE;
    good       = 1'b0;
    wr_pay     = 1'b0;
    if (cap) begin
      case (rx_state)
        HUNT:    if (r_data == SYNC_BYTE) rx_state_n = LEN_H;
        LEN_H:   rx_state_n = LEN_L;
        LEN_L: begin
          if (new_len == 16'd0 || {1'b0, new_len} > MAX_LEN_L) begin
            set_flag   = 1'b1;
            rx_state_n = HUNT;
          end else begin
            rx_state_n = PAYLOAD;
          end
        end
        PAYLOAD: begin
          wr_pay = 1'b1;
          if (idx == len - 16'd1) rx_state_n = CSUM;
        end
        CSUM: begin
          set_flag   = 1'b1;
          rx_state_n = HUNT;
          if (r_data == csum) begin
            good     = 1'b1;
            set_byte = ACK_BYTE;
          end
        end
        default: rx_state_n = HUNT;
      endcase
    end else if (tmo_hit) begin
      set_flag   = 1'b1;
      rx_state_n = HUNT;
    end
    flag_n  = set_flag | (flag_pend & ~flag_clr);
    rd_next = ((rx_state_n != HUNT) || !flag_n) && !rx_empty && !rd_uart;
  end

  // RX registers: state, fetch pipeline, length/index/checksum, write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state   <= HUNT;
      rd_uart    <= 1'b0;
      cap        <= 1'b0;
      len_hi     <= '0;
      len        <= '0;
      idx        <= '0;
      csum       <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      flag_pend  <= 1'b0;
      flag_byte  <= '0;
    end else begin
      rx_state   <= rx_state_n;
      rd_uart    <= rd_next;
      cap        <= rd_uart;
      mem_we     <= wr_pay;
      frame_done <= good;
      flag_pend  <= flag_n;
      if (set_flag) flag_byte <= set_byte;
      if (good) frame_len <= len;
      if (cap && rx_state == LEN_H) len_hi <= r_data;
      if (cap && rx_state == LEN_L) begin
        len  <= new_len;
        idx  <= '0;
        csum <= '0;
      end
      if (wr_pay) begin
        mem_addr  <= ADDR_W'(idx);
        mem_wdata <= r_data;
        idx       <= idx + 16'd1;
        csum      <= csum + r_data;
      end
    end
  end

  // TX scheduler: ACK/NAK beats results only from T_IDLE; result pair is atomic.
  always_comb begin
    tx_state_n = tx_state;
    wr_uart    = 1'b0;
    w_data     = 8'h00;
    res_ready  = 1'b0;
    flag_clr   = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (flag_pend)      tx_state_n = T_ACK;
        else if (res_valid) tx_state_n = T_HDR;
      end
      T_ACK: begin
        w_data = flag_byte;
        if (!tx_full) begin
          wr_uart    = 1'b1;
          flag_clr   = 1'b1;
          tx_state_n = T_IDLE;
        end
      end
      T_HDR: begin
        w_data = RES_HDR;
        if (!tx_full) begin
          wr_uart    = 1'b1;
          res_ready  = 1'b1;
          tx_state_n = T_DATA;
        end
      end
      T_DATA: begin
        w_data = res_q;
        if (!tx_full) begin
          wr_uart    = 1'b1;
          tx_state_n = T_IDLE;
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  // TX state register and result-ID latch taken with the header write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= T_IDLE;
      res_q    <= '0;
    end else begin
      tx_state <= tx_state_n;
      if (res_ready) res_q <= res_data;
    end
  end

endmodule
